// File: rtl/image_loader.sv
// Single-frame image buffer: fills NPIX greyscale pixels from a valid/ready stream,
// then replays them once on request as zero-extended Q8.8 pixels.

module image_loader #(
    parameter int NPIX  = 784,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             clear,
    input  logic             start,
    output logic [OUT_W-1:0] pixel_out,
    output logic             pixel_valid,
    output logic             done,
    output logic             img_ready,
    output logic [7:0]       frame_cnt
);
    localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic [IDX_W-1:0] rd_idx_r;
    logic [IN_W-1:0]  mem_r [NPIX];
    logic             s_ready_r;
    logic             img_ready_r;
    logic             pixel_valid_r;
    logic             done_r;
    logic [OUT_W-1:0] pixel_out_r;
    logic [7:0]       frame_cnt_r;
    logic             we_s;
    logic             re_s;

    // Buffer write/read strobes; s_ready_r gates the write so the first cycle out of reset accepts nothing.
    always_comb begin
        we_s = 1'b0;
        re_s = 1'b0;
        case (state_r)
            FILL:    we_s = s_ready_r & s_valid & ~clear;
            FULL:    re_s = start & ~clear;
            STREAM:  re_s = 1'b1;
            default: re_s = 1'b0;
        endcase
    end

    // Pixel storage, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wr_idx_r] <= s_data;
        end
    end

    // Loader FSM with registered handshake, stream and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= FILL;
            wr_idx_r      <= '0;
            rd_idx_r      <= '0;
            s_ready_r     <= 1'b0;
            img_ready_r   <= 1'b0;
            pixel_valid_r <= 1'b0;
            pixel_out_r   <= '0;
            done_r        <= 1'b0;
            frame_cnt_r   <= 8'd0;
        end else begin
            done_r        <= 1'b0;
            pixel_valid_r <= re_s;
            pixel_out_r   <= re_s ? OUT_W'(mem_r[rd_idx_r]) : '0;
            case (state_r)
                FILL: begin
                    s_ready_r   <= 1'b1;
                    img_ready_r <= 1'b0;
                    if (clear) begin
                        wr_idx_r <= '0;
                    end else if (we_s) begin
                        if (wr_idx_r == LAST_IDX) begin
                            wr_idx_r    <= '0;
                            state_r     <= FULL;
                            s_ready_r   <= 1'b0;
                            img_ready_r <= 1'b1;
                        end else begin
                            wr_idx_r <= wr_idx_r + IDX_W'(1);
                        end
                    end else begin
                        wr_idx_r <= wr_idx_r;
                    end
                end
                FULL: begin
                    if (clear) begin
                        state_r     <= FILL;
                        s_ready_r   <= 1'b1;
                        img_ready_r <= 1'b0;
                    end else if (start) begin
                        img_ready_r <= 1'b0;
                        if (rd_idx_r == LAST_IDX) begin
                            rd_idx_r <= '0;
                            state_r  <= FINISH;
                        end else begin
                            rd_idx_r <= rd_idx_r + IDX_W'(1);
                            state_r  <= STREAM;
                        end
                    end else begin
                        img_ready_r <= 1'b1;
                    end
                end
                STREAM: begin
                    // start is deliberately not looked at here: a stream always runs to completion.
                    if (rd_idx_r == LAST_IDX) begin
                        rd_idx_r <= '0;
                        state_r  <= FINISH;
                    end else begin
                        rd_idx_r <= rd_idx_r + IDX_W'(1);
                    end
                end
                FINISH: begin
                    done_r      <= 1'b1;
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                    s_ready_r   <= 1'b1;
                    state_r     <= FILL;
                end
                default: begin
                    state_r   <= FILL;
                    wr_idx_r  <= '0;
                    rd_idx_r  <= '0;
                    s_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_r;
    assign img_ready   = img_ready_r;
    assign pixel_valid = pixel_valid_r;
    assign pixel_out   = pixel_out_r;
    assign done        = done_r;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_image_loader.sv
// Directed/randomised bench for image_loader: a frame model (array of accepted pixels,
// frame counter) predicts every streamed pixel, handshake level and done/frame_cnt.

module tb_image_loader;
    localparam int NPIX  = 784;
    localparam int SNPIX = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid, clear, start;
    logic        s_ready, pixel_valid, done, img_ready;
    logic [15:0] pixel_out;
    logic [7:0]  frame_cnt;

    logic [7:0]  s2_data;
    logic        s2_valid, s2_clear, s2_start;
    logic        s2_ready, s2_pixel_valid, s2_done, s2_img_ready;
    logic [15:0] s2_pixel_out;
    logic [7:0]  s2_frame_cnt;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int exp_frame = 0;
    logic [7:0] exp_img  [NPIX];
    logic [7:0] s2_img   [SNPIX];

    always #5 clk = ~clk;

    image_loader #(.NPIX(NPIX), .IN_W(8), .OUT_W(16)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .clear(clear), .start(start), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .done(done), .img_ready(img_ready), .frame_cnt(frame_cnt)
    );

    image_loader #(.NPIX(SNPIX), .IN_W(8), .OUT_W(16)) dut_small (
        .clk(clk), .reset(reset), .s_data(s2_data), .s_valid(s2_valid), .s_ready(s2_ready),
        .clear(s2_clear), .start(s2_start), .pixel_out(s2_pixel_out), .pixel_valid(s2_pixel_valid),
        .done(s2_done), .img_ready(s2_img_ready), .frame_cnt(s2_frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // mode 0: k mod 256, mode 1: constant 0xAB, mode 2: random grey levels
    task automatic load_image(input int mode, input int valid_pct, input bit rand_start);
        int cnt = 0;
        while (cnt < NPIX) begin
            @(negedge clk);
            check("s_ready_fill", s_ready, 1);
            check("pv_fill", pixel_valid, 0);
            check("pout_fill", pixel_out, 0);
            s_valid = ($urandom_range(99) < valid_pct);
            s_data  = (mode == 0) ? 8'(cnt) : (mode == 1) ? 8'hAB : 8'($urandom);
            if (rand_start) start = 1'($urandom_range(1));
            if (s_valid) begin
                exp_img[cnt] = s_data;
                cnt++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("s_ready_full", s_ready, 0);
        check("img_ready_full", img_ready, 1);
        check("pv_full", pixel_valid, 0);
    endtask

    // Entered at the FULL cycle; start is sampled at its end.
    task automatic stream_image(input bit busy_valid, input bit wobble_start);
        start = 1'b1;
        if (busy_valid) begin s_valid = 1'b1; s_data = 8'($urandom); end
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            check("pv_stream", pixel_valid, 1);
            check("pout_stream", pixel_out, {8'h00, exp_img[k]});
            check("s_ready_stream", s_ready, 0);
            check("done_stream", done, 0);
            check("img_ready_stream", img_ready, 0);
            if (busy_valid) s_data = 8'($urandom);
            if (wobble_start) start = 1'($urandom_range(1));
        end
        @(negedge clk);
        s_valid = 1'b0;
        exp_frame = (exp_frame + 1) % 256;
        check("done_pulse", done, 1);
        check("pv_after", pixel_valid, 0);
        check("pout_after", pixel_out, 0);
        check("frame_cnt", frame_cnt, exp_frame);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("done_once", done, 0);
            check("pv_no_restart", pixel_valid, 0);
            check("img_ready_empty", img_ready, 0);
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; s_data = 8'd0; s_valid = 1'b0; clear = 1'b0; start = 1'b0;
        s2_data = 8'd0; s2_valid = 1'b0; s2_clear = 1'b0; s2_start = 1'b0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_pv", pixel_valid, 0);
        check("rst_pout", pixel_out, 0);
        check("rst_done", done, 0);
        check("rst_img_ready", img_ready, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        reset = 1'b1;

        // Ramp image, start held throughout the fill.
        start = 1'b1;
        load_image(0, 100, 1'b0);
        stream_image(1'b0, 1'b0);

        // Partial load, clear with a pixel offered, then a constant image.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 8'($urandom);
        end
        @(negedge clk);
        clear = 1'b1; s_valid = 1'b1; s_data = 8'h55;
        @(negedge clk);
        clear = 1'b0; s_valid = 1'b0;
        load_image(1, 100, 1'b0);
        stream_image(1'b0, 1'b1);

        // Clear while FULL drops the image.
        load_image(2, 100, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_full_img_ready", img_ready, 0);
        check("clear_full_s_ready", s_ready, 1);

        // 50% valid with random start in fill, then s_valid held busy during stream.
        load_image(2, 50, 1'b1);
        stream_image(1'b1, 1'b1);
        load_image(2, 70, 1'b0);
        stream_image(1'b0, 1'b0);

        // Asynchronous reset in the middle of a stream.
        load_image(2, 100, 1'b0);
        start = 1'b1;
        for (int k = 0; k <= 400; k++) begin
            @(negedge clk);
            check("pv_pre_reset", pixel_valid, 1);
            check("pout_pre_reset", pixel_out, {8'h00, exp_img[k]});
        end
        #2 reset = 1'b0;
        #1;
        check("areset_pv", pixel_valid, 0);
        check("areset_pout", pixel_out, 0);
        check("areset_done", done, 0);
        check("areset_frame_cnt", frame_cnt, 0);
        check("areset_s_ready", s_ready, 0);
        exp_frame = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_reset_done", done, 0);
            check("in_reset_pv", pixel_valid, 0);
        end
        start = 1'b0;
        reset = 1'b1;
        load_image(2, 100, 1'b0);
        stream_image(1'b0, 1'b0);

        // Frame counter wrap on a small instance: 257 images.
        for (int img = 1; img <= 257; img++) begin
            for (int p = 0; p < SNPIX; p++) begin
                @(negedge clk);
                s2_valid = 1'b1; s2_data = 8'($urandom);
                s2_img[p] = s2_data;
            end
            @(negedge clk);
            s2_valid = 1'b0;
            s2_start = 1'b1;
            check("s2_img_ready", s2_img_ready, 1);
            for (int k = 0; k < SNPIX; k++) begin
                @(negedge clk);
                check("s2_pout", s2_pixel_out, {8'h00, s2_img[k]});
            end
            @(negedge clk);
            s2_start = 1'b0;
            check("s2_done", s2_done, 1);
            check("s2_frame_cnt", s2_frame_cnt, img % 256);
        end
        check("s2_wrap", s2_frame_cnt, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001: Parameter NPIX, default 784, SHALL set pixels per image (28x28).
REQ-002: Parameter IN_W, default 8, SHALL set the input pixel width (unsigned grey level).
REQ-003: Parameter OUT_W, default 16, SHALL set the output pixel width (Q8.8 fixed point).
REQ-004: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005: reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-006: s_data  input  IN_W  SHALL carry the incoming pixel, raster order, pixel 0 first.
REQ-007: s_valid  input  1  SHALL qualify s_data.
REQ-008: s_ready  output  1  SHALL indicate the loader accepts s_data this cycle.
REQ-009: clear  input  1  SHALL synchronously discard a partially loaded image.
REQ-010: start  input  1  SHALL request streaming of the loaded image (level, held by the sequencer until done).
REQ-011: pixel_out  output  OUT_W  SHALL carry the streamed pixel.
REQ-012: pixel_valid  output  1  SHALL qualify pixel_out.
REQ-013: done  output  1  SHALL pulse one cycle after the last streamed pixel.
REQ-014: img_ready  output  1  SHALL be high while a complete image is buffered and not yet streamed.
REQ-015: frame_cnt  output  8  SHALL count completed image streams, wrapping 255->0.

Function
REQ-016: Storage SHALL be an NPIX x IN_W buffer with registered (1-cycle) read; write index wr_idx and read index rd_idx are each ceil(log2(NPIX)) bits.
REQ-017: FSM states SHALL be FILL, FULL, STREAM, FINISH.
REQ-018: FILL: s_ready=1; each cycle with s_valid=1 writes s_data at wr_idx and increments wr_idx.
REQ-019: FILL->FULL when the write at wr_idx=NPIX-1 occurs; wr_idx returns to 0.
REQ-020: FULL: s_ready=0, img_ready=1; s_valid ignored, no data lost from the buffer.
REQ-021: FULL->STREAM on the first cycle start=1 is sampled; rd_idx=0 is issued that cycle.
REQ-022: STREAM: one read per cycle, rd_idx 0..NPIX-1 contiguously, no bubbles; start deasserting mid-stream SHALL NOT stop the stream.
REQ-023: pixel_valid SHALL rise the cycle after FULL->STREAM and stay high exactly NPIX consecutive cycles.
REQ-024: pixel_out SHALL be {(OUT_W-IN_W) zeros, buffer[k]}, i.e. grey/256 in Q8.8; pixel_out SHALL be 0 whenever pixel_valid=0.
REQ-025: STREAM->FINISH after the read of rd_idx=NPIX-1 is issued; FINISH drives the last pixel_valid.
REQ-026: done=1 for exactly one cycle, the cycle after the last pixel_valid; frame_cnt increments that same cycle; state returns to FILL.
REQ-027: start=1 while in FILL (including the cycle after done) SHALL have no effect; a new stream needs a new full image.
REQ-028: start=1 while s_valid=1 in FILL: the pixel is accepted; start ignored.
REQ-029: clear=1 in FILL: wr_idx<=0, accepted pixel that cycle discarded; clear in FULL drops the image (->FILL); clear in STREAM/FINISH ignored.
REQ-030: Latency: start sampled at cycle N -> pixel 0 valid at N+1, pixel NPIX-1 at N+NPIX, done at N+NPIX+1.

Reset
REQ-031: reset=0 SHALL asynchronously force state FILL, wr_idx=0, rd_idx=0, s_ready=0 while asserted, pixel_valid=0, pixel_out=0, done=0, img_ready=0, frame_cnt=0; buffer contents need not be cleared.
REQ-032: After reset release s_ready SHALL be 1 from the first clock edge; reset mid-stream aborts with no further pixel_valid or done.

Verification
REQ-033: Load pixels k mod 256 (k=0..783), hold start=1 -> 784 contiguous pixel_valid, pixel_out=k mod 256, done one cycle after, frame_cnt=1.
REQ-034: Load 300 pixels, clear, load full image of 0xAB -> streamed data all 0x00AB, count 784, no stale data.
REQ-035: s_valid toggling 50% during fill, start held from reset -> stream begins exactly one cycle after img_ready rises; s_ready=0 from FULL until done.
REQ-036: Drive s_valid=1 continuously during FULL/STREAM -> no buffer corruption; streamed image equals first image; second image loads after done.
REQ-037: Assert reset=0 at pixel 400 of stream -> outputs zero immediately (asynchronous), no done, frame_cnt=0, next full image streams normally.
REQ-038: Run 257 images -> frame_cnt wraps to 1.
